// File: rtl/fpu_scoreboard_if.sv
// ----------------------------------------------------------------------------
// fpu_scoreboard_if
// Bundles the issue-stage request and hazard/writeback response signals of
// the FPU scoreboard so decode-side logic and the scoreboard share one port.
//
// Signals:
//   rs_i            packed source indices, src k at [k*REG_AW +: REG_AW]
//   use_rs          per-source valid
//   issue_valid     decoded op present at issue
//   issue_regwrite  op writes an FP register
//   issue_rd        destination register index
//   issue_lat       cycles until the result can be forwarded/written
//   flush           pipeline squash, clears all tracking
//   hazard          stall request (OR of the three hazard terms)
//   hazard_raw      a used source is still pending
//   hazard_waw      an older write to rd completes at or after this one
//   hazard_wb       writeback slot at issue_lat already reserved
//   issue_fire      op leaves issue this cycle
//   wb_expect_valid a tracked write reaches writeback this cycle
//   wb_expect_rd    destination of that write
//   busy            any tracking state is live
//
// Modports:
//   master  issue-stage side (drives the request, observes the response)
//   slave   scoreboard side
// ----------------------------------------------------------------------------
interface fpu_scoreboard_if #(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 3,
   parameter int LAT_W   = 4
);
   logic [NUM_SRC*REG_AW-1:0] rs_i;
   logic [NUM_SRC-1:0]        use_rs;
   logic                      issue_valid;
   logic                      issue_regwrite;
   logic [REG_AW-1:0]         issue_rd;
   logic [LAT_W-1:0]          issue_lat;
   logic                      flush;
   logic                      hazard;
   logic                      hazard_raw;
   logic                      hazard_waw;
   logic                      hazard_wb;
   logic                      issue_fire;
   logic                      wb_expect_valid;
   logic [REG_AW-1:0]         wb_expect_rd;
   logic                      busy;

   modport master (
      output rs_i, use_rs, issue_valid, issue_regwrite, issue_rd, issue_lat, flush,
      input  hazard, hazard_raw, hazard_waw, hazard_wb, issue_fire,
             wb_expect_valid, wb_expect_rd, busy
   );

   modport slave (
      input  rs_i, use_rs, issue_valid, issue_regwrite, issue_rd, issue_lat, flush,
      output hazard, hazard_raw, hazard_waw, hazard_wb, issue_fire,
             wb_expect_valid, wb_expect_rd, busy
   );
endinterface

// File: rtl/fpu_scoreboard.sv
// ----------------------------------------------------------------------------
// fpu_scoreboard
// Issue-stage hazard tracker for variable-latency FPU pipes. Keeps a
// pending-latency counter per FP register plus a shift register of
// writeback-slot reservations, and flags RAW, WAW and writeback-port
// conflicts for the op currently at issue.
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset, clears all tracking
//   bus   fpu_scoreboard_if.slave, issue request in / hazard and
//         writeback-expectation response out
// ----------------------------------------------------------------------------
module fpu_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int REG_AW   = 5,
   parameter int NUM_SRC  = 3,
   parameter int MAX_LAT  = 8,
   parameter int LAT_W    = 4
) (
   input logic               clk,
   input logic               rstn,
   fpu_scoreboard_if.slave   bus
);

   logic [LAT_W-1:0]  r_cnt    [NUM_REGS];
   logic [MAX_LAT-1:0] r_slotV;
   logic [REG_AW-1:0] r_slotRd [MAX_LAT];

   logic [LAT_W-1:0]  w_lat;
   logic [LAT_W-1:0]  w_latM1;
   logic [LAT_W-1:0]  w_rdCnt;
   logic              w_slotAtLat;
   logic              w_raw;
   logic              w_waw;
   logic              w_wb;
   logic              w_hazard;
   logic              w_fire;
   logic              w_record;
   logic              w_anyCnt;

   // Normalise the requested latency: zero behaves like a single-cycle op,
   // and anything beyond the deepest pipe is treated as the deepest pipe.
   always_comb begin
      if (bus.issue_lat == '0) begin
         w_lat = LAT_W'(1);
      end else if (bus.issue_lat > LAT_W'(MAX_LAT)) begin
         w_lat = LAT_W'(MAX_LAT);
      end else begin
         w_lat = bus.issue_lat;
      end
      w_latM1 = w_lat - LAT_W'(1);
   end

   // A source is blocked while its producer's counter is nonzero; a zero
   // counter means the value is already forwardable this cycle.
   always_comb begin
      w_raw = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (bus.use_rs[k] && (bus.rs_i[k*REG_AW +: REG_AW] == REG_AW'(r)) &&
                (r_cnt[r] != '0)) begin
               w_raw = 1'b1;
            end
         end
      end
      w_raw = w_raw & bus.issue_valid;
   end

   // Look up the destination's counter and whether the writeback slot the
   // new op would land in is already taken. A slot at index issue_lat is the
   // one that shifts into position issue_lat-1 alongside the new reservation;
   // index MAX_LAT does not exist, so a maximum-latency op never collides.
   always_comb begin
      w_rdCnt     = '0;
      w_slotAtLat = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (bus.issue_rd == REG_AW'(r)) begin
            w_rdCnt = r_cnt[r];
         end
      end
      for (int i = 1; i < MAX_LAT; i++) begin
         if (w_lat == LAT_W'(i)) begin
            w_slotAtLat = r_slotV[i];
         end
      end
   end

   // Combine the hazard terms. Flush deliberately only reaches the stall
   // path through issue_fire so a squash never looks like a hazard.
   always_comb begin
      w_waw    = bus.issue_valid & bus.issue_regwrite & (w_rdCnt >= w_lat);
      w_wb     = bus.issue_valid & bus.issue_regwrite & w_slotAtLat;
      w_hazard = w_raw | w_waw | w_wb;
      w_fire   = bus.issue_valid & ~w_hazard & ~bus.flush;
      w_record = w_fire & bus.issue_regwrite;
      w_anyCnt = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (r_cnt[r] != '0) begin
            w_anyCnt = 1'b1;
         end
      end
   end

   // Per-register pending counters. A firing write loads L-1 so the counter
   // hits zero exactly in its writeback cycle; that load takes precedence
   // over the ordinary saturating countdown of the same register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_cnt[r] <= '0;
         end
      end else if (bus.flush) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_cnt[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (w_record && (bus.issue_rd == REG_AW'(r))) begin
               r_cnt[r] <= w_latM1;
            end else if (r_cnt[r] != '0) begin
               r_cnt[r] <= r_cnt[r] - LAT_W'(1);
            end
         end
      end
   end

   // Writeback-slot reservations. Slot i holds the write that reaches the
   // register file i cycles from now, so everything moves down one place per
   // cycle and slot 0 is the write landing this cycle. The new reservation
   // goes in after the shift; hazard_wb guarantees that slot is free.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_slotV <= '0;
         for (int i = 0; i < MAX_LAT; i++) begin
            r_slotRd[i] <= '0;
         end
      end else if (bus.flush) begin
         r_slotV <= '0;
         for (int i = 0; i < MAX_LAT; i++) begin
            r_slotRd[i] <= '0;
         end
      end else begin
         for (int i = 0; i < MAX_LAT - 1; i++) begin
            r_slotV[i]  <= r_slotV[i+1];
            r_slotRd[i] <= r_slotRd[i+1];
         end
         r_slotV[MAX_LAT-1]  <= 1'b0;
         r_slotRd[MAX_LAT-1] <= '0;
         if (w_record) begin
            for (int i = 0; i < MAX_LAT; i++) begin
               if (w_latM1 == LAT_W'(i)) begin
                  r_slotV[i]  <= 1'b1;
                  r_slotRd[i] <= bus.issue_rd;
               end
            end
         end
      end
   end

   // Slot 0 is itself a register, so the writeback expectation is driven
   // straight from it and lines up with the cycle the write actually lands.
   assign bus.hazard          = w_hazard;
   assign bus.hazard_raw      = w_raw;
   assign bus.hazard_waw      = w_waw;
   assign bus.hazard_wb       = w_wb;
   assign bus.issue_fire      = w_fire;
   assign bus.wb_expect_valid = r_slotV[0];
   assign bus.wb_expect_rd    = r_slotRd[0];
   assign bus.busy            = w_anyCnt | (|r_slotV);

endmodule

// File: tb/tb_fpu_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_fpu_scoreboard
// Self-checking bench for fpu_scoreboard. The reference model keeps a plain
// list of in-flight writes (destination + absolute writeback cycle) and
// derives every hazard and writeback expectation from that list. Stimulus
// pushes expectations into queues; a monitor on the falling edge pops and
// compares them against the DUT.
// ----------------------------------------------------------------------------
module tb_fpu_scoreboard;

   localparam int NUM_REGS = 32;
   localparam int REG_AW   = 5;
   localparam int NUM_SRC  = 3;
   localparam int MAX_LAT  = 8;
   localparam int LAT_W    = 4;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   fpu_scoreboard_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .LAT_W(LAT_W)) bus ();

   fpu_scoreboard #(
      .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC),
      .MAX_LAT(MAX_LAT), .LAT_W(LAT_W)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   typedef struct {
      int rd;
      int t;
   } write_t;

   typedef struct {
      bit raw;
      bit waw;
      bit wb;
      bit fire;
      bit busy;
   } exp_t;

   write_t pending[$];
   write_t wbQ[$];
   exp_t   expQ[$];

   int cyc          = 0;
   int nVectors     = 0;
   int nMiscompares = 0;

   // Single point of comparison; every check steps the counters printed in
   // the summary line.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Drive one cycle of issue-stage inputs just after the rising edge, then
   // work out from the list of in-flight writes what the scoreboard must say
   // about this op, and update that list with whatever the op starts.
   task automatic applyStimulus(input bit rst, input bit iv, input bit rw,
                                input bit fl, input int rd, input int lat,
                                input int s0, input int s1, input int s2,
                                input bit [2:0] useMask);
      int  src [3];
      int  effLat;
      int  rdM;
      exp_t e;
      int  pos;
      write_t w;

      @(posedge clk);
      #1;
      cyc++;

      if (rst) begin
         rstn = 1'b0;
         pending.delete();
         wbQ.delete();
      end else begin
         rstn = 1'b1;
      end

      rdM    = rd & 31;
      src[0] = s0 & 31;
      src[1] = s1 & 31;
      src[2] = s2 & 31;
      bus.issue_valid    = iv;
      bus.issue_regwrite = rw;
      bus.flush          = fl;
      bus.issue_rd       = REG_AW'(rdM);
      bus.issue_lat      = LAT_W'(lat & 15);
      bus.use_rs         = useMask;
      bus.rs_i           = {REG_AW'(src[2]), REG_AW'(src[1]), REG_AW'(src[0])};

      for (int i = pending.size() - 1; i >= 0; i--) begin
         if (pending[i].t < cyc) pending.delete(i);
      end

      effLat = lat & 15;
      if (effLat == 0) effLat = 1;
      if (effLat > MAX_LAT) effLat = MAX_LAT;

      e = '{raw: 1'b0, waw: 1'b0, wb: 1'b0, fire: 1'b0, busy: 1'b0};
      foreach (pending[i]) begin
         if (pending[i].t >= cyc) e.busy = 1'b1;
         if (iv) begin
            for (int k = 0; k < NUM_SRC; k++) begin
               if (useMask[k] && pending[i].rd == src[k] && pending[i].t > cyc) e.raw = 1'b1;
            end
            if (rw && pending[i].rd == rdM && pending[i].t >= cyc + effLat) e.waw = 1'b1;
            if (rw && pending[i].t == cyc + effLat) e.wb = 1'b1;
         end
      end
      e.fire = iv && !(e.raw || e.waw || e.wb) && !fl;
      expQ.push_back(e);

      if (e.fire && rw && !rst) begin
         w.rd = rdM;
         w.t  = cyc + effLat;
         pending.push_back(w);
         pos = wbQ.size();
         for (int i = 0; i < wbQ.size(); i++) begin
            if (wbQ[i].t > w.t) begin
               pos = i;
               break;
            end
         end
         wbQ.insert(pos, w);
      end

      if (fl) begin
         for (int i = pending.size() - 1; i >= 0; i--) begin
            if (pending[i].t > cyc) pending.delete(i);
         end
         for (int i = wbQ.size() - 1; i >= 0; i--) begin
            if (wbQ[i].t > cyc) wbQ.delete(i);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000);
   endtask

   task automatic issueOp(input int rd, input int lat);
      applyStimulus(0, 1, 1, 0, rd, lat, 0, 0, 0, 3'b000);
   endtask

   task automatic consume(input int src);
      applyStimulus(0, 1, 0, 0, 0, 1, src, 0, 0, 3'b001);
   endtask

   task automatic resetCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000);
   endtask

   // Monitor: on every falling edge compare the combinational hazard view
   // and the writeback expectation against what the stimulus side queued.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("hazard_raw", 32'(bus.hazard_raw), 32'(e.raw));
            checkOutput("hazard_waw", 32'(bus.hazard_waw), 32'(e.waw));
            checkOutput("hazard_wb",  32'(bus.hazard_wb),  32'(e.wb));
            checkOutput("hazard",     32'(bus.hazard),     32'(e.raw | e.waw | e.wb));
            checkOutput("issue_fire", 32'(bus.issue_fire), 32'(e.fire));
            checkOutput("busy",       32'(bus.busy),       32'(e.busy));
            if (wbQ.size() > 0 && wbQ[0].t == cyc) begin
               checkOutput("wb_expect_valid", 32'(bus.wb_expect_valid), 32'd1);
               checkOutput("wb_expect_rd",    32'(bus.wb_expect_rd),    32'(wbQ[0].rd));
               void'(wbQ.pop_front());
            end else begin
               checkOutput("wb_expect_valid", 32'(bus.wb_expect_valid), 32'd0);
            end
         end
      end
   end

   // Hard time limit so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios first, then a long randomized stream.
   initial begin
      bus.rs_i           = '0;
      bus.use_rs         = '0;
      bus.issue_valid    = 1'b0;
      bus.issue_regwrite = 1'b0;
      bus.issue_rd       = '0;
      bus.issue_lat      = LAT_W'(1);
      bus.flush          = 1'b0;

      resetCycles(3);
      idle(2);

      $display("[TB] RAW on a 4-cycle producer");
      issueOp(3, 4);
      repeat (5) consume(3);
      idle(MAX_LAT);

      $display("[TB] back-to-back single-cycle ops");
      issueOp(5, 1);
      applyStimulus(0, 1, 1, 0, 6, 1, 5, 0, 0, 3'b001);
      idle(MAX_LAT);

      $display("[TB] WAW on the same destination");
      issueOp(2, 6);
      repeat (6) issueOp(2, 2);
      idle(MAX_LAT);

      $display("[TB] writeback-port conflict and its resolution");
      issueOp(1, 3);
      issueOp(4, 2);
      idle(MAX_LAT);
      issueOp(1, 3);
      issueOp(4, 3);
      idle(MAX_LAT);

      $display("[TB] latency clamping");
      issueOp(7, 0);
      issueOp(8, 12);
      repeat (MAX_LAT + 1) consume(8);
      issueOp(9, 8);
      issueOp(10, 8);
      idle(MAX_LAT + 1);

      $display("[TB] flush with an op at issue");
      issueOp(9, 5);
      issueOp(10, 7);
      applyStimulus(0, 1, 1, 1, 11, 2, 9, 0, 0, 3'b000);
      idle(3);

      $display("[TB] reset mid-stream");
      issueOp(12, 8);
      issueOp(13, 3);
      idle(1);
      resetCycles(2);
      idle(1);
      consume(12);
      consume(13);
      idle(2);

      $display("[TB] randomized stream");
      for (int n = 0; n < 4000; n++) begin
         bit rst, iv, rw, fl;
         int lat;
         rst = ($urandom_range(0, 399) == 0);
         fl  = ($urandom_range(0, 59) == 0);
         iv  = ($urandom_range(0, 3) != 0);
         rw  = ($urandom_range(0, 3) != 0);
         lat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15))
                                           : int'($urandom_range(1, MAX_LAT));
         applyStimulus(rst, rst ? 1'b0 : iv, rw, fl,
                       int'($urandom_range(0, 7)), lat,
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end

      idle(MAX_LAT + 3);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
